// File: rtl/id_ex_hazard_ctrl_pkg.sv
// Shared types and defaults for the ID/EX hazard controller.
// Holds the state encoding, the zero-register constant and the register-match helper.
package id_ex_hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         MDU_LAT_DEF = 32;
  localparam int         CNT_W_DEF   = 16;

  // A source operand collides with a producer only if the operand is actually read.
  function automatic logic reg_hit(input logic uses, input logic [4:0] src, input logic [4:0] dst);
    return uses & (src == dst);
  endfunction

endpackage

// File: rtl/id_ex_hazard_ctrl_sat_counter.sv
// Saturating up-counter with increment enable and async active-low reset.
// It holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: step by one unless already at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// Control side of the ID/EX register: load-use, MDU occupancy and branch redirect.
// It drives the bubble and hold/clear lines and keeps a saturating stall counter.
module id_ex_hazard_ctrl
  import id_ex_hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             r_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_mdu_start,
  input  logic             id_mdu_read,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_dst,
  input  logic             br_taken,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int              MC_W       = $clog2(MDU_LAT + 1);
  localparam logic [MC_W-1:0] MDU_RELOAD = MC_W'(MDU_LAT - 1);
  localparam logic [MC_W-1:0] MDU_IDLE   = {MC_W{1'b0}};

  hz_state_e       state_q;
  hz_state_e       state_d;
  logic [MC_W-1:0] mdu_cnt_q;
  logic [MC_W-1:0] mdu_cnt_d;

  logic lu_s;
  logic md_s;
  logic stall_s;
  logic accept_s;

  // Hazard terms; a taken branch squashes the ID instruction, so it masks every stall.
  always_comb begin
    lu_s     = ex_mem_read & ex_reg_write & (ex_dst != REG_ZERO) &
               (reg_hit(id_uses_rs, id_rs, ex_dst) | reg_hit(id_uses_rt, id_rt, ex_dst));
    md_s     = (state_q == ST_MDU_WAIT) & (id_mdu_start | id_mdu_read);
    stall_s  = (lu_s | md_s) & ~br_taken;
    accept_s = id_mdu_start & ~stall_s & ~br_taken;
  end

  // MDU occupancy: reload on accept, otherwise drain by one, even across stalls and flushes.
  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    state_d   = state_q;
    if (accept_s) begin
      mdu_cnt_d = MDU_RELOAD;
    end else if (mdu_cnt_q != MDU_IDLE) begin
      mdu_cnt_d = mdu_cnt_q - MC_W'(1);
    end else begin
      mdu_cnt_d = mdu_cnt_q;
    end
    if (mdu_cnt_d != MDU_IDLE) begin
      state_d = ST_MDU_WAIT;
    end else begin
      state_d = ST_RUN;
    end
  end

  // State register; state tracks whether the occupancy counter is nonzero.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state_q   <= ST_RUN;
      mdu_cnt_q <= MDU_IDLE;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(r_n),
    .inc  (stall_s),
    .cnt  (stall_cnt)
  );

  // Control lines are forced low while reset is asserted.
  assign pc_stall   = stall_s & r_n;
  assign ifid_stall = stall_s & r_n;
  assign idex_flush = (stall_s | br_taken) & r_n;
  assign ifid_flush = br_taken & r_n;
  assign mdu_busy   = (state_q == ST_MDU_WAIT);

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Directed bench for id_ex_hazard_ctrl: one short-latency/narrow-counter instance
// and one default-parameter instance share the same stimulus.
module tb_id_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       r_n;
  logic [4:0] id_rs, id_rt, ex_dst;
  logic       id_uses_rs, id_uses_rt, id_mdu_start, id_mdu_read;
  logic       ex_mem_read, ex_reg_write, br_taken;

  logic        a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_flush, a_mdu_busy;
  logic [2:0]  a_stall_cnt;
  logic        d_pc_stall, d_ifid_stall, d_ifid_flush, d_idex_flush, d_mdu_busy;
  logic [15:0] d_stall_cnt;

  int total = 0;
  int bad   = 0;

  // flags = {pc_stall, ifid_stall, ifid_flush, idex_flush, mdu_busy}
  wire [4:0] a_flags = {a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_flush, a_mdu_busy};
  wire [4:0] d_flags = {d_pc_stall, d_ifid_stall, d_ifid_flush, d_idex_flush, d_mdu_busy};

  always #5 clk = ~clk;

  id_ex_hazard_ctrl #(.MDU_LAT(4), .CNT_W(3)) dut (
    .clk(clk), .r_n(r_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_mdu_start(id_mdu_start), .id_mdu_read(id_mdu_read),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_dst(ex_dst),
    .br_taken(br_taken), .pc_stall(a_pc_stall), .ifid_stall(a_ifid_stall),
    .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush), .mdu_busy(a_mdu_busy),
    .stall_cnt(a_stall_cnt)
  );

  id_ex_hazard_ctrl dut_def (
    .clk(clk), .r_n(r_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_mdu_start(id_mdu_start), .id_mdu_read(id_mdu_read),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_dst(ex_dst),
    .br_taken(br_taken), .pc_stall(d_pc_stall), .ifid_stall(d_ifid_stall),
    .ifid_flush(d_ifid_flush), .idex_flush(d_idex_flush), .mdu_busy(d_mdu_busy),
    .stall_cnt(d_stall_cnt)
  );

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_dst = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_mdu_start = 1'b0; id_mdu_read = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; br_taken = 1'b0;
  endtask

  task automatic set_lu_rt(input logic [4:0] dst, input logic [4:0] rt);
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = dst;
    id_uses_rt = 1'b1; id_rt = rt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    r_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    r_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    r_n = 1'b0;
    set_lu_rt(5'd8, 5'd8);
    #1;
    total++;
    if (a_flags !== 5'b00000) begin
      $display("FAIL reset_flags got=%b exp=%b", a_flags, 5'b00000); bad++;
    end
    total++;
    if (a_stall_cnt !== 3'd0 || d_stall_cnt !== 16'd0) begin
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", a_stall_cnt, d_stall_cnt); bad++;
    end
    @(negedge clk);
    clear_inputs();
    r_n = 1'b1;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    set_lu_rt(5'd8, 5'd8);
    #1;
    total++;
    if (a_flags !== 5'b11010) begin
      $display("FAIL lu_rt_stall got=%b exp=%b", a_flags, 5'b11010); bad++;
    end
    @(negedge clk);
    clear_inputs();
    #1;
    total++;
    if (a_flags !== 5'b00000) begin
      $display("FAIL lu_rt_release got=%b exp=%b", a_flags, 5'b00000); bad++;
    end
    total++;
    if (a_stall_cnt !== 3'd1 || d_stall_cnt !== 16'd1) begin
      $display("FAIL lu_rt_cnt got=%0d/%0d exp=1/1", a_stall_cnt, d_stall_cnt); bad++;
    end
    // rs side match, but rt unused and mismatching
    @(negedge clk);
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd9;
    id_uses_rs = 1'b1; id_rs = 5'd9; id_rt = 5'd3;
    #1;
    total++;
    if (a_flags !== 5'b11010) begin
      $display("FAIL lu_rs_stall got=%b exp=%b", a_flags, 5'b11010); bad++;
    end
    // same match with uses_rs low, and a non-load producer: no stall
    @(negedge clk);
    id_uses_rs = 1'b0;
    #1;
    total++;
    if (a_flags !== 5'b00000) begin
      $display("FAIL lu_rs_unused got=%b exp=%b", a_flags, 5'b00000); bad++;
    end
    @(negedge clk);
    id_uses_rs = 1'b1; ex_mem_read = 1'b0;
    #1;
    total++;
    if (a_flags !== 5'b00000) begin
      $display("FAIL lu_not_load got=%b exp=%b", a_flags, 5'b00000); bad++;
    end
    @(negedge clk);
    clear_inputs();
    #1;
    total++;
    if (a_stall_cnt !== 3'd2) begin
      $display("FAIL lu_rs_cnt got=%0d exp=2", a_stall_cnt); bad++;
    end
  endtask

  task automatic test_zero_dst();
    @(negedge clk);
    set_lu_rt(5'd0, 5'd0);
    #1;
    total++;
    if (a_flags !== 5'b00000) begin
      $display("FAIL zero_dst_flags got=%b exp=%b", a_flags, 5'b00000); bad++;
    end
    @(negedge clk);
    clear_inputs();
    #1;
    total++;
    if (a_stall_cnt !== 3'd2) begin
      $display("FAIL zero_dst_cnt got=%0d exp=2", a_stall_cnt); bad++;
    end
  endtask

  task automatic test_mdu();
    logic [4:0] exp_flags [0:4];
    exp_flags[0] = 5'b00000; exp_flags[1] = 5'b00001; exp_flags[2] = 5'b11011;
    exp_flags[3] = 5'b11011; exp_flags[4] = 5'b00000;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      id_mdu_start = (c == 0);
      id_mdu_read  = (c >= 2);
      #1;
      total++;
      if (a_flags !== exp_flags[c]) begin
        $display("FAIL mdu_cycle%0d got=%b exp=%b", c, a_flags, exp_flags[c]); bad++;
      end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    total++;
    if (a_stall_cnt !== 3'd2) begin
      $display("FAIL mdu_cnt got=%0d exp=2", a_stall_cnt); bad++;
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_flags [0:5];
    exp_flags[0] = 5'b00000; exp_flags[1] = 5'b11011; exp_flags[2] = 5'b11011;
    exp_flags[3] = 5'b11011; exp_flags[4] = 5'b00000; exp_flags[5] = 5'b00001;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      id_mdu_start = (c <= 4);
      #1;
      total++;
      if (a_flags !== exp_flags[c]) begin
        $display("FAIL b2b_cycle%0d got=%b exp=%b", c, a_flags, exp_flags[c]); bad++;
      end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    total++;
    if (a_stall_cnt !== 3'd5) begin
      $display("FAIL b2b_cnt got=%0d exp=5", a_stall_cnt); bad++;
    end
  endtask

  task automatic test_branch();
    do_reset();
    @(negedge clk);
    set_lu_rt(5'd8, 5'd8);
    id_mdu_start = 1'b1;
    br_taken = 1'b1;
    #1;
    total++;
    if (a_flags !== 5'b00110) begin
      $display("FAIL br_flags got=%b exp=%b", a_flags, 5'b00110); bad++;
    end
    @(negedge clk);
    clear_inputs();
    #1;
    total++;
    if (a_flags !== 5'b00000 || d_mdu_busy !== 1'b0) begin
      $display("FAIL br_no_accept got=%b/%b exp=00000/0", a_flags, d_mdu_busy); bad++;
    end
    total++;
    if (a_stall_cnt !== 3'd0) begin
      $display("FAIL br_cnt got=%0d exp=0", a_stall_cnt); bad++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    id_mdu_start = 1'b1;
    @(negedge clk);
    id_mdu_start = 1'b0;
    id_mdu_read = 1'b1;
    #1;
    total++;
    if (d_flags !== 5'b11011) begin
      $display("FAIL ar_busy_stall got=%b exp=%b", d_flags, 5'b11011); bad++;
    end
    @(negedge clk);
    #1;
    total++;
    if (d_flags !== 5'b11011 || d_stall_cnt !== 16'd1) begin
      $display("FAIL ar_pre got=%b/%0d exp=11011/1", d_flags, d_stall_cnt); bad++;
    end
    #2;
    r_n = 1'b0;
    #1;
    total++;
    if (d_flags !== 5'b00000 || d_stall_cnt !== 16'd0) begin
      $display("FAIL ar_cleared got=%b/%0d exp=00000/0", d_flags, d_stall_cnt); bad++;
    end
    @(negedge clk);
    clear_inputs();
    r_n = 1'b1;
    id_mdu_start = 1'b1;
    #1;
    total++;
    if (d_flags !== 5'b00000) begin
      $display("FAIL ar_release got=%b exp=%b", d_flags, 5'b00000); bad++;
    end
    @(negedge clk);
    id_mdu_start = 1'b0;
    #1;
    total++;
    if (d_mdu_busy !== 1'b1 || a_mdu_busy !== 1'b1) begin
      $display("FAIL ar_accept got=%b/%b exp=1/1", d_mdu_busy, a_mdu_busy); bad++;
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_lu_rt(5'd12, 5'd12);
      #1;
      exp_cnt = (i > 7) ? 7 : i;
      total++;
      if (a_flags !== 5'b11010 || a_stall_cnt !== 3'(exp_cnt)) begin
        $display("FAIL sat_step%0d got=%b/%0d exp=11010/%0d", i, a_flags, a_stall_cnt, exp_cnt); bad++;
      end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    total++;
    if (a_stall_cnt !== 3'd7 || d_stall_cnt !== 16'd10) begin
      $display("FAIL sat_final got=%0d/%0d exp=7/10", a_stall_cnt, d_stall_cnt); bad++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    r_n = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_zero_dst();
    test_mdu();
    test_back_to_back();
    test_branch();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
